nvme_queue_ctrl: RTL and testbench

Multi-queue NVMe doorbell controller: brings the link through configuration, then tracks SQ tail / CQ head pointers and outstanding-command counts for NUM_QUEUES queue pairs (qid 0 = admin). Accepted submit/consume requests advance the pointer with wrap at QUEUE_DEPTH and produce one doorbell write each. A doorbell-completion timeout is included. Sits between the command/completion engines and the PCIe doorbell-write engine.

---
 rtl/nvme_queue_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_nvme_queue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_queue_ctrl.sv
// NVMe doorbell controller: link bring-up, per-queue SQ tail / CQ head tracking,
// one doorbell write per accepted request, with a doorbell-completion timeout.
module nvme_queue_ctrl #(
  parameter int          NUM_QUEUES  = 4,
  parameter int          QUEUE_DEPTH = 16,
  parameter int          DSTRD       = 0,
  parameter logic [63:0] DB_BASE     = 64'h1000,
  parameter int          DB_TIMEOUT  = 1024,
  localparam int         QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int         PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1
) (
  input  logic          user_clk,
  input  logic          user_reset_n,
  input  logic          user_lnk_up,
  output logic          start_config,
  input  logic          cfg_done,
  input  logic          sq_req_valid,
  input  logic [QW-1:0] sq_req_qid,
  output logic          sq_req_ready,
  input  logic          cq_req_valid,
  input  logic [QW-1:0] cq_req_qid,
  output logic          cq_req_ready,
  output logic          sq_reject,
  output logic          cq_reject,
  output logic          db_write,
  output logic [63:0]   db_addr,
  output logic [31:0]   db_value,
  input  logic          db_done,
  output logic          err,
  output logic [3:0]    ctl_state
);

  localparam int            TW      = $clog2(DB_TIMEOUT + 1);
  localparam int            SH      = 2 + DSTRD;
  localparam logic [QW:0]   NQ      = (QW + 1)'(NUM_QUEUES);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(QUEUE_DEPTH - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_LAST  = TW'(DB_TIMEOUT - 1);

  typedef enum logic [3:0] {
    WAIT_LNKUP = 4'd0,
    START_CFG  = 4'd1,
    WAIT_CFG   = 4'd2,
    IDLE       = 4'd3,
    DB_WAIT    = 4'd4,
    ERROR      = 4'd5
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] sq_tail     [NUM_QUEUES];
  logic [PW-1:0] cq_head     [NUM_QUEUES];
  logic [PW-1:0] outstanding [NUM_QUEUES];
  logic [TW-1:0] tmo_cnt;

  logic          sq_ok, cq_ok;
  logic [QW-1:0] sq_idx, cq_idx;
  logic [PW-1:0] sq_tail_nxt, cq_head_nxt;
  logic          do_sq, do_cq, rej_sq, rej_cq, go_error;

  assign sq_ok  = {1'b0, sq_req_qid} < NQ;
  assign cq_ok  = {1'b0, cq_req_qid} < NQ;
  assign sq_idx = sq_ok ? sq_req_qid : '0;
  assign cq_idx = cq_ok ? cq_req_qid : '0;

  assign sq_tail_nxt = (sq_tail[sq_idx] == P_LAST) ? '0 : sq_tail[sq_idx] + P_ONE;
  assign cq_head_nxt = (cq_head[cq_idx] == P_LAST) ? '0 : cq_head[cq_idx] + P_ONE;

  // Consume wins over submit, so submit only sees ready when no consume is pending.
  assign cq_req_ready = (state == IDLE);
  assign sq_req_ready = (state == IDLE) && !cq_req_valid;
  assign start_config = (state == START_CFG);
  assign ctl_state    = state;

  always_comb begin
    state_nxt = state;
    do_sq     = 1'b0;
    do_cq     = 1'b0;
    rej_sq    = 1'b0;
    rej_cq    = 1'b0;
    go_error  = 1'b0;
    case (state)
      WAIT_LNKUP: state_nxt = START_CFG;
      START_CFG:  state_nxt = WAIT_CFG;
      WAIT_CFG:   if (cfg_done) state_nxt = IDLE;
      IDLE: begin
        if (cq_req_valid) begin
          if (cq_ok && (outstanding[cq_idx] != '0)) begin
            do_cq     = 1'b1;
            state_nxt = DB_WAIT;
          end else begin
            rej_cq = 1'b1;
          end
        end else if (sq_req_valid) begin
          if (sq_ok && (outstanding[sq_idx] != P_LAST)) begin
            do_sq     = 1'b1;
            state_nxt = DB_WAIT;
          end else begin
            rej_sq = 1'b1;
          end
        end
      end
      DB_WAIT: begin
        if (db_done) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == T_LAST) begin
          state_nxt = ERROR;
          go_error  = 1'b1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = WAIT_LNKUP;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state <= WAIT_LNKUP;
    end else if (!user_lnk_up) begin
      state <= WAIT_LNKUP;
    end else begin
      state <= state_nxt;
    end
  end

  // A link drop clears everything exactly like reset, abandoning any doorbell in flight.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        sq_tail[i]     <= '0;
        cq_head[i]     <= '0;
        outstanding[i] <= '0;
      end
      tmo_cnt   <= '0;
      db_write  <= 1'b0;
      db_addr   <= '0;
      db_value  <= '0;
      sq_reject <= 1'b0;
      cq_reject <= 1'b0;
      err       <= 1'b0;
    end else if (!user_lnk_up) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        sq_tail[i]     <= '0;
        cq_head[i]     <= '0;
        outstanding[i] <= '0;
      end
      tmo_cnt   <= '0;
      db_write  <= 1'b0;
      db_addr   <= '0;
      db_value  <= '0;
      sq_reject <= 1'b0;
      cq_reject <= 1'b0;
      err       <= 1'b0;
    end else begin
      db_write  <= do_sq | do_cq;
      sq_reject <= rej_sq;
      cq_reject <= rej_cq;
      if (do_cq) begin
        cq_head[cq_idx]     <= cq_head_nxt;
        outstanding[cq_idx] <= outstanding[cq_idx] - P_ONE;
        db_addr             <= DB_BASE + (64'({cq_idx, 1'b1}) << SH);
        db_value            <= 32'(cq_head_nxt);
      end else if (do_sq) begin
        sq_tail[sq_idx]     <= sq_tail_nxt;
        outstanding[sq_idx] <= outstanding[sq_idx] + P_ONE;
        db_addr             <= DB_BASE + (64'({sq_idx, 1'b0}) << SH);
        db_value            <= 32'(sq_tail_nxt);
      end
      if (do_sq | do_cq) begin
        tmo_cnt <= '0;
      end else if ((state == DB_WAIT) && !db_done && !go_error) begin
        tmo_cnt <= tmo_cnt + T_ONE;
      end
      if (go_error) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nvme_queue_ctrl.sv
// Bench for nvme_queue_ctrl: a queue-level model checks the default instance every cycle;
// a second instance (3 queues, DSTRD=2) is pinned with hand-computed literals.
module tb_nvme_queue_ctrl;

  localparam int          M_NQ     = 4;
  localparam int          M_DEPTH  = 16;
  localparam int          M_STRIDE = 4;
  localparam logic [63:0] M_BASE   = 64'h1000;
  localparam int          M_TO     = 1024;

  logic       user_clk = 1'b0;
  logic       user_reset_n, user_lnk_up, cfg_done, db_done;
  logic       sq_req_valid, cq_req_valid;
  logic [1:0] sq_req_qid, cq_req_qid;

  logic        d1_start_config, d1_sq_req_ready, d1_cq_req_ready, d1_sq_reject, d1_cq_reject;
  logic        d1_db_write, d1_err;
  logic [63:0] d1_db_addr;
  logic [31:0] d1_db_value;
  logic [3:0]  d1_ctl_state;

  logic        d2_start_config, d2_sq_req_ready, d2_cq_req_ready, d2_sq_reject, d2_cq_reject;
  logic        d2_db_write, d2_err;
  logic [63:0] d2_db_addr;
  logic [31:0] d2_db_value;
  logic [3:0]  d2_ctl_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 user_clk = ~user_clk;

  nvme_queue_ctrl dut1 (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .start_config(d1_start_config), .cfg_done(cfg_done),
    .sq_req_valid(sq_req_valid), .sq_req_qid(sq_req_qid), .sq_req_ready(d1_sq_req_ready),
    .cq_req_valid(cq_req_valid), .cq_req_qid(cq_req_qid), .cq_req_ready(d1_cq_req_ready),
    .sq_reject(d1_sq_reject), .cq_reject(d1_cq_reject),
    .db_write(d1_db_write), .db_addr(d1_db_addr), .db_value(d1_db_value),
    .db_done(db_done), .err(d1_err), .ctl_state(d1_ctl_state)
  );

  nvme_queue_ctrl #(.NUM_QUEUES(3), .DSTRD(2)) dut2 (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .start_config(d2_start_config), .cfg_done(cfg_done),
    .sq_req_valid(sq_req_valid), .sq_req_qid(sq_req_qid), .sq_req_ready(d2_sq_req_ready),
    .cq_req_valid(cq_req_valid), .cq_req_qid(cq_req_qid), .cq_req_ready(d2_cq_req_ready),
    .sq_reject(d2_sq_reject), .cq_reject(d2_cq_reject),
    .db_write(d2_db_write), .db_addr(d2_db_addr), .db_value(d2_db_value),
    .db_done(db_done), .err(d2_err), .ctl_state(d2_ctl_state)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue-level reference: pointers as modular counters, addresses by plain arithmetic.
  int          m_state = 0;
  int          m_tcnt  = 0;
  int          m_val   = 0;
  int          m_tail [M_NQ] = '{default: 0};
  int          m_head [M_NQ] = '{default: 0};
  int          m_out  [M_NQ] = '{default: 0};
  logic [63:0] m_addr  = '0;
  bit          m_dbw = 1'b0, m_sqrej = 1'b0, m_cqrej = 1'b0, m_err = 1'b0;

  task automatic modelClear();
    m_state = 0; m_tcnt = 0; m_val = 0; m_addr = '0;
    m_dbw = 1'b0; m_sqrej = 1'b0; m_cqrej = 1'b0; m_err = 1'b0;
    for (int i = 0; i < M_NQ; i++) begin
      m_tail[i] = 0; m_head[i] = 0; m_out[i] = 0;
    end
  endtask

  task automatic modelRing(input int db_index, input int v);
    m_addr  = M_BASE + 64'(db_index * M_STRIDE);
    m_val   = v;
    m_dbw   = 1'b1;
    m_state = 4;
    m_tcnt  = 0;
  endtask

  always @(posedge user_clk or negedge user_reset_n) begin
    int q;
    if (!user_reset_n || !user_lnk_up) begin
      modelClear();
    end else begin
      m_dbw = 1'b0; m_sqrej = 1'b0; m_cqrej = 1'b0;
      case (m_state)
        0: m_state = 1;
        1: m_state = 2;
        2: if (cfg_done) m_state = 3;
        3: begin
          if (cq_req_valid) begin
            q = int'(cq_req_qid);
            if (q >= M_NQ || m_out[q] == 0) m_cqrej = 1'b1;
            else begin
              m_head[q] = (m_head[q] + 1) % M_DEPTH;
              m_out[q]--;
              modelRing(2 * q + 1, m_head[q]);
            end
          end else if (sq_req_valid) begin
            q = int'(sq_req_qid);
            if (q >= M_NQ || m_out[q] == M_DEPTH - 1) m_sqrej = 1'b1;
            else begin
              m_tail[q] = (m_tail[q] + 1) % M_DEPTH;
              m_out[q]++;
              modelRing(2 * q, m_tail[q]);
            end
          end
        end
        4: begin
          if (db_done) m_state = 3;
          else begin
            m_tcnt++;
            if (m_tcnt >= M_TO) begin
              m_state = 5;
              m_err   = 1'b1;
            end
          end
        end
        default: m_state = m_state;
      endcase
    end
  end

  always @(negedge user_clk) begin
    checkOutput("state", d1_ctl_state, m_state);
    checkOutput("start_config", d1_start_config, m_state == 1);
    checkOutput("cq_ready", d1_cq_req_ready, m_state == 3);
    checkOutput("sq_ready", d1_sq_req_ready, (m_state == 3) && !cq_req_valid);
    checkOutput("db_write", d1_db_write, m_dbw);
    checkOutput("sq_reject", d1_sq_reject, m_sqrej);
    checkOutput("cq_reject", d1_cq_reject, m_cqrej);
    checkOutput("db_addr", d1_db_addr, m_addr);
    checkOutput("db_value", d1_db_value, m_val);
    checkOutput("err", d1_err, m_err);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic bringUp();
    tick(1);
    checkOutput("lit_cfg_state", d1_ctl_state, 1);
    checkOutput("lit_start_pulse", d1_start_config, 1);
    checkOutput("lit_ready_early", d1_cq_req_ready, 0);
    tick(1);
    checkOutput("lit_start_once", d1_start_config, 0);
    tick(3);
    cfg_done = 1'b1;
    tick(1);
    cfg_done = 1'b0;
    checkOutput("lit_idle", d1_ctl_state, 3);
    checkOutput("lit_idle2", d2_ctl_state, 3);
  endtask

  // Presents one request for one cycle; on return we sit in the cycle after the accept edge.
  task automatic applyStimulus(input bit is_cq, input logic [1:0] q, input bit with_done);
    if (is_cq) begin cq_req_valid = 1'b1; cq_req_qid = q; end
    else       begin sq_req_valid = 1'b1; sq_req_qid = q; end
    tick(1);
    cq_req_valid = 1'b0;
    sq_req_valid = 1'b0;
    db_done      = with_done;
  endtask

  task automatic endRound();
    tick(1);
    db_done = 1'b0;
  endtask

  initial begin
    user_reset_n = 1'b0; user_lnk_up = 1'b0; cfg_done = 1'b0; db_done = 1'b0;
    sq_req_valid = 1'b0; cq_req_valid = 1'b0; sq_req_qid = '0; cq_req_qid = '0;
    #3;
    checkOutput("lit_rst_state", d1_ctl_state, 0);
    checkOutput("lit_rst_addr", d1_db_addr, 0);
    checkOutput("lit_rst_err", d2_err, 0);
    checkOutput("lit_rst_ready", d1_cq_req_ready, 0);
    #9;
    user_reset_n = 1'b1;
    user_lnk_up  = 1'b1;
    bringUp();

    applyStimulus(1'b0, 2'd2, 1'b1);
    checkOutput("lit_q2_write", d1_db_write, 1);
    checkOutput("lit_q2_addr", d1_db_addr, 64'h1010);
    checkOutput("lit_q2_value", d1_db_value, 1);
    checkOutput("lit_q2_addr_d2", d2_db_addr, 64'h1040);
    endRound();
    checkOutput("lit_q2_idle", d1_ctl_state, 3);
    checkOutput("lit_q2_single", d1_db_write, 0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 2'd1, 1'b1);
      endRound();
    end
    checkOutput("lit_fill_value", d1_db_value, 15);
    checkOutput("lit_fill_addr", d1_db_addr, 64'h1008);
    applyStimulus(1'b0, 2'd1, 1'b1);
    checkOutput("lit_full_reject", d1_sq_reject, 1);
    checkOutput("lit_full_nowrite", d1_db_write, 0);
    endRound();
    applyStimulus(1'b1, 2'd1, 1'b1);
    checkOutput("lit_cq1_addr", d1_db_addr, 64'h100C);
    checkOutput("lit_cq1_value", d1_db_value, 1);
    checkOutput("lit_cq1_addr_d2", d2_db_addr, 64'h1030);
    endRound();
    applyStimulus(1'b0, 2'd1, 1'b1);
    checkOutput("lit_wrap_value", d1_db_value, 0);
    endRound();

    sq_req_valid = 1'b1; sq_req_qid = 2'd0;
    cq_req_valid = 1'b1; cq_req_qid = 2'd0;
    #1;
    checkOutput("lit_prio_sq_stall", d1_sq_req_ready, 0);
    tick(1);
    checkOutput("lit_prio_cq_reject", d1_cq_reject, 1);
    checkOutput("lit_prio_no_sq_reject", d1_sq_reject, 0);
    cq_req_valid = 1'b0;
    tick(1);
    sq_req_valid = 1'b0;
    db_done = 1'b1;
    checkOutput("lit_prio_sq_addr", d1_db_addr, 64'h1000);
    checkOutput("lit_prio_sq_value", d1_db_value, 1);
    endRound();

    applyStimulus(1'b0, 2'd3, 1'b1);
    checkOutput("lit_q3_reject_d2", d2_sq_reject, 1);
    checkOutput("lit_q3_addr_d1", d1_db_addr, 64'h1018);
    endRound();

    applyStimulus(1'b0, 2'd0, 1'b0);
    tick(M_TO - 1);
    checkOutput("lit_tmo_still_wait", d1_ctl_state, 4);
    checkOutput("lit_tmo_no_err", d1_err, 0);
    tick(1);
    checkOutput("lit_tmo_state", d1_ctl_state, 5);
    checkOutput("lit_tmo_err", d1_err, 1);
    checkOutput("lit_tmo_ready", d1_cq_req_ready, 0);
    checkOutput("lit_tmo_state_d2", d2_ctl_state, 5);
    db_done = 1'b1;
    tick(2);
    db_done = 1'b0;
    checkOutput("lit_late_done", d1_ctl_state, 5);
    sq_req_valid = 1'b1;
    tick(2);
    sq_req_valid = 1'b0;
    user_lnk_up = 1'b0;
    tick(1);
    checkOutput("lit_drop_state", d1_ctl_state, 0);
    checkOutput("lit_drop_err", d1_err, 0);
    checkOutput("lit_drop_addr", d1_db_addr, 0);
    user_lnk_up = 1'b1;
    bringUp();
    applyStimulus(1'b0, 2'd2, 1'b1);
    checkOutput("lit_cleared_value", d1_db_value, 1);
    endRound();

    applyStimulus(1'b0, 2'd1, 1'b0);
    checkOutput("lit_ar_write", d2_db_write, 1);
    #2;
    user_reset_n = 1'b0;
    #1;
    checkOutput("lit_ar_state", d2_ctl_state, 0);
    checkOutput("lit_ar_addr", d2_db_addr, 0);
    checkOutput("lit_ar_value", d2_db_value, 0);
    checkOutput("lit_ar_write0", d2_db_write, 0);
    checkOutput("lit_ar_state_d1", d1_ctl_state, 0);
    @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    bringUp();
    applyStimulus(1'b0, 2'd1, 1'b1);
    checkOutput("lit_dstrd_addr", d2_db_addr, 64'h1020);
    checkOutput("lit_dstrd_value", d2_db_value, 1);
    checkOutput("lit_ar_addr_d1", d1_db_addr, 64'h1008);
    endRound();

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
